// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: default widths, the
// read-return source tags and the arbiter state encoding.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    // Identifies who issued a memory command so read data can be routed back
    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_CPU  = 2'b01,
        SRC_DBG  = 2'b10
    } src_tag_e;

    // CPU normally wins; debug is forced through once it has waited too long
    typedef enum logic {
        ARB_CPU_PRIO  = 1'b0,
        ARB_DBG_FORCE = 1'b1
    } arb_state_e;

    // Tag to push into the return pipe for an accepted command: only reads
    // produce return data, writes and idle cycles push SRC_NONE
    function automatic src_tag_e read_tag(input logic acc, input logic we,
                                          input src_tag_e src);
        if (acc && !we) begin
            return src;
        end else begin
            return SRC_NONE;
        end
    endfunction

endpackage

// File: rtl/data_mem_arbiter_read_return_pipe.sv
// Read return path: carries each command's source tag alongside the memory
// read latency and steers the returning data to the requester that asked.
module read_return_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        push_tag,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [1:0]        tag_r [READ_LAT];
    logic [1:0]        head_tag_s;
    logic              cpu_rvalid_r;
    logic              dbg_rvalid_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dbg_rdata_r;

    // Tag shift register: a tag reaches the head exactly when its data is on mem_data_out
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                tag_r[i] <= SRC_NONE;
            end
        end else begin
            tag_r[0] <= push_tag;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign head_tag_s = tag_r[READ_LAT-1];

    // Return stage: register memory data into the owner's rdata and pulse its rvalid
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_rvalid_r <= 1'b0;
            dbg_rvalid_r <= 1'b0;
            cpu_rdata_r  <= {DATA_W{1'b0}};
            dbg_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            cpu_rvalid_r <= 1'b0;
            dbg_rvalid_r <= 1'b0;
            case (head_tag_s)
                SRC_CPU: begin
                    cpu_rvalid_r <= 1'b1;
                    cpu_rdata_r  <= mem_data_out;
                end
                SRC_DBG: begin
                    dbg_rvalid_r <= 1'b1;
                    dbg_rdata_r  <= mem_data_out;
                end
                default: begin
                    cpu_rdata_r <= cpu_rdata_r;
                    dbg_rdata_r <= dbg_rdata_r;
                end
            endcase
        end
    end

    assign cpu_rvalid = cpu_rvalid_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign dbg_rvalid = dbg_rvalid_r;
    assign dbg_rdata  = dbg_rdata_r;

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and a
// debug/loader port. CPU has priority; a wait counter guarantees the debug
// port a slot after a bounded wait. The winner is registered into a one-deep
// command stage that drives the memory; read data returns via a tagged pipe.
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LAT     = 1,
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // Counter only has to reach DBG_MAX_WAIT; keep at least one bit for the 0 case
    localparam int WAIT_W = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    arb_state_e        arb_state_s;
    logic              cpu_gnt_s;
    logic              dbg_gnt_s;
    logic              cpu_acc_s;
    logic              dbg_acc_s;
    src_tag_e          acc_tag_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_data_in_r;

    // Arbiter state: debug is forced once it is requesting and has waited long enough
    always_comb begin
        arb_state_s = ARB_CPU_PRIO;
        if (dbg_req && (wait_cnt_r >= WAIT_MAX)) begin
            arb_state_s = ARB_DBG_FORCE;
        end else begin
            arb_state_s = ARB_CPU_PRIO;
        end
    end

    // Grant generation: at most one grant per cycle, none while in reset
    always_comb begin
        cpu_gnt_s = 1'b0;
        dbg_gnt_s = 1'b0;
        if (!reset) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else begin
            case (arb_state_s)
                ARB_CPU_PRIO: begin
                    cpu_gnt_s = cpu_req;
                    dbg_gnt_s = dbg_req & ~cpu_req;
                end
                ARB_DBG_FORCE: begin
                    cpu_gnt_s = 1'b0;
                    dbg_gnt_s = 1'b1;
                end
                default: begin
                    cpu_gnt_s = 1'b0;
                    dbg_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign cpu_acc_s = cpu_req & cpu_gnt_s;
    assign dbg_acc_s = dbg_req & dbg_gnt_s;

    // Source tag of this cycle's accepted command (NONE for writes and idle)
    always_comb begin
        acc_tag_s = SRC_NONE;
        if (cpu_acc_s) begin
            acc_tag_s = read_tag(cpu_acc_s, cpu_we, SRC_CPU);
        end else if (dbg_acc_s) begin
            acc_tag_s = read_tag(dbg_acc_s, dbg_we, SRC_DBG);
        end else begin
            acc_tag_s = SRC_NONE;
        end
    end

    // Wait counter: counts consecutive denied debug cycles, saturating at the limit
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (dbg_req && !dbg_gnt_s) begin
            if (wait_cnt_r < WAIT_MAX) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    // Command stage: registers the winner; address and data hold when idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_data_in_r <= {DATA_W{1'b0}};
        end else if (cpu_acc_s) begin
            mem_read_r    <= ~cpu_we;
            mem_write_r   <= cpu_we;
            mem_addr_r    <= cpu_addr;
            mem_data_in_r <= cpu_wdata;
        end else if (dbg_acc_s) begin
            mem_read_r    <= ~dbg_we;
            mem_write_r   <= dbg_we;
            mem_addr_r    <= dbg_addr;
            mem_data_in_r <= dbg_wdata;
        end else begin
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
        end
    end

    read_return_pipe #(
        .DATA_W  (DATA_W),
        .READ_LAT(READ_LAT)
    ) u_read_return_pipe (
        .clk         (clk),
        .reset       (reset),
        .push_tag    (acc_tag_s),
        .mem_data_out(mem_data_out),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata)
    );

    assign cpu_gnt     = cpu_gnt_s;
    assign dbg_gnt     = dbg_gnt_s;
    assign cpu_stall   = cpu_req & ~cpu_gnt_s;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign mem_addr    = mem_addr_r;
    assign mem_data_in = mem_data_in_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (READ_LAT=1 and READ_LAT=2) share
// one directed stimulus stream. A reference model predicts grants and the
// command stage and pushes expected read returns; a monitor pops and compares.
module tb_data_mem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW   = 6;
    localparam int DW   = 8;
    localparam int MAXW = 4;
    localparam int LAT_A = 1;
    localparam int LAT_B = 2;

    typedef struct packed {
        logic [1:0]  src;
        logic [7:0]  data;
        logic [31:0] due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;

    logic          a_cpu_gnt, a_cpu_stall, a_cpu_rvalid, a_dbg_gnt, a_dbg_rvalid;
    logic [DW-1:0] a_cpu_rdata, a_dbg_rdata, a_mem_data_in, a_mem_data_out;
    logic          a_mem_read, a_mem_write;
    logic [AW-1:0] a_mem_addr;
    logic          b_cpu_gnt, b_cpu_stall, b_cpu_rvalid, b_dbg_gnt, b_dbg_rvalid;
    logic [DW-1:0] b_cpu_rdata, b_dbg_rdata, b_mem_data_in, b_mem_data_out;
    logic          b_mem_read, b_mem_write;
    logic [AW-1:0] b_mem_addr;

    logic [DW-1:0] mem_a [64];
    logic [DW-1:0] mem_b [64];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] b_dly;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT_A), .DBG_MAX_WAIT(MAXW)) u_dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(a_cpu_gnt), .cpu_stall(a_cpu_stall), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(a_dbg_gnt), .dbg_rvalid(a_dbg_rvalid), .dbg_rdata(a_dbg_rdata),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
        .mem_data_in(a_mem_data_in), .mem_data_out(a_mem_data_out));

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT_B), .DBG_MAX_WAIT(MAXW)) u_dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_stall(b_cpu_stall), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_data_in(b_mem_data_in), .mem_data_out(b_mem_data_out));

    // Memory behind instance A: data valid one edge after the address is presented
    always @(posedge clk) if (a_mem_write) mem_a[a_mem_addr] <= a_mem_data_in;
    assign a_mem_data_out = mem_a[a_mem_addr];

    // Memory behind instance B: one extra register for a two-cycle read
    always @(posedge clk) begin
        if (b_mem_write) mem_b[b_mem_addr] <= b_mem_data_in;
        b_dly <= mem_b[b_mem_addr];
    end
    assign b_mem_data_out = b_dly;

    // Edge counter used to time-stamp expected returns
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon_one(input bit is_b, input logic cv, input logic [7:0] cd,
                           input logic dv, input logic [7:0] dd);
        exp_t e;
        int   n;
        string nm;
        nm = is_b ? "B" : "A";
        n  = is_b ? q_b.size() : q_a.size();
        if (cv || dv) begin
            if (n == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected_rvalid: got cpu=%0b dbg=%0b required none (cyc %0d)",
                         nm, cv, dv, cyc);
            end else begin
                if (is_b) e = q_b.pop_front();
                else      e = q_a.pop_front();
                chk({nm, " rvalid_src"}, {30'd0, dv, cv}, {30'd0, e.src});
                chk({nm, " rdata"}, cv ? cd : dd, e.data);
                chk({nm, " rvalid_cycle"}, cyc, e.due);
            end
        end else if (n > 0) begin
            e = is_b ? q_b[0] : q_a[0];
            if (e.due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missing_rvalid: got none required src=%0d data=%0h (cyc %0d)",
                         nm, e.src, e.data, cyc);
                if (is_b) void'(q_b.pop_front());
                else      void'(q_a.pop_front());
            end
        end
    endtask

    // Monitor: compare read returns against the scoreboard queues
    always @(negedge clk) begin
        mon_one(1'b0, a_cpu_rvalid, a_cpu_rdata, a_dbg_rvalid, a_dbg_rdata);
        mon_one(1'b1, b_cpu_rvalid, b_cpu_rdata, b_dbg_rvalid, b_dbg_rdata);
    end

    // Reference model: arbitration, wait counter, command stage, expected returns
    logic          e_rd = 1'b0, e_wr = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0;
    int            wait_m = 0;
    always @(negedge clk) begin
        logic eg_c, eg_d, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic [1:0] src;
        #1;
        chk("A cmd_stage", {a_mem_read, a_mem_write, a_mem_addr, a_mem_data_in}, {e_rd, e_wr, e_addr, e_wd});
        chk("B cmd_stage", {b_mem_read, b_mem_write, b_mem_addr, b_mem_data_in}, {e_rd, e_wr, e_addr, e_wd});
        eg_c = 1'b0;
        eg_d = 1'b0;
        if (reset) begin
            if (dbg_req && wait_m >= MAXW) eg_d = 1'b1;
            else begin
                eg_c = cpu_req;
                eg_d = dbg_req & ~cpu_req;
            end
        end
        chk("A grants", {a_cpu_gnt, a_dbg_gnt, a_cpu_stall}, {eg_c, eg_d, cpu_req & ~eg_c});
        chk("B grants", {b_cpu_gnt, b_dbg_gnt, b_cpu_stall}, {eg_c, eg_d, cpu_req & ~eg_c});
        if (!reset) begin
            e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
            wait_m = 0;
            q_a.delete();
            q_b.delete();
        end else begin
            if (eg_c || eg_d) begin
                we  = eg_c ? cpu_we : dbg_we;
                ad  = eg_c ? cpu_addr : dbg_addr;
                wd  = eg_c ? cpu_wdata : dbg_wdata;
                src = eg_c ? 2'b01 : 2'b10;
                e_rd = ~we; e_wr = we; e_addr = ad; e_wd = wd;
                if (we) ref_mem[ad] = wd;
                else begin
                    q_a.push_back('{src: src, data: ref_mem[ad], due: cyc + 1 + LAT_A});
                    q_b.push_back('{src: src, data: ref_mem[ad], due: cyc + 1 + LAT_B});
                end
            end else begin
                e_rd = 1'b0; e_wr = 1'b0;
            end
            if (dbg_req && !eg_d) wait_m = (wait_m < MAXW) ? wait_m + 1 : wait_m;
            else wait_m = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus with hand-computed spot checks
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 8'(i * 17);
            mem_b[i] = 8'(i * 17);
            ref_mem[i] = 8'(i * 17);
        end
        mem_a[5] = 8'hA5; mem_b[5] = 8'hA5; ref_mem[5] = 8'hA5;

        // 1: reset held with both requesting
        reset = 1'b0; cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
        cpu_addr = 6'h00; dbg_addr = 6'h01;
        step(); step();
        @(negedge clk);
        chk("rst gnt", {a_cpu_gnt, a_dbg_gnt}, 2'b00);
        chk("rst mem", {a_mem_read, a_mem_write, a_mem_addr, a_mem_data_in}, 16'h0000);
        chk("rst rvalid", {a_cpu_rvalid, a_dbg_rvalid, b_cpu_rvalid, b_dbg_rvalid}, 4'h0);
        chk("rst rdata", {a_cpu_rdata, a_dbg_rdata}, 16'h0000);
        step();
        reset = 1'b1;
        // 3: both held, debug forced every fifth cycle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("starve pattern", {a_cpu_gnt, a_dbg_gnt, a_cpu_stall},
                (i % 5 == 4) ? 3'b011 : 3'b100);
            step();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (4) step();

        // 2: CPU read of 05
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h05;
        @(negedge clk); chk("t2 gnt", a_cpu_gnt, 1'b1);
        step(); cpu_req = 1'b0;
        @(negedge clk); chk("t2 mem", {a_mem_read, a_mem_addr}, {1'b1, 6'h05});
        step();
        @(negedge clk); chk("t2 ret", {a_cpu_rvalid, a_dbg_rvalid, a_cpu_rdata}, {2'b10, 8'hA5});
        step();
        @(negedge clk); chk("t2 pulse", a_cpu_rvalid, 1'b0);
        repeat (3) step();

        // 4: write 10<=3C then read 10
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h10; cpu_wdata = 8'h3C;
        step(); cpu_we = 1'b0;
        @(negedge clk); chk("t4 wr", {a_mem_write, a_mem_read, a_mem_data_in}, {2'b10, 8'h3C});
        step(); cpu_req = 1'b0;
        @(negedge clk); chk("t4 rd", {a_mem_write, a_mem_read}, 2'b01);
        step();
        @(negedge clk); chk("t4 ret", {a_cpu_rvalid, a_cpu_rdata}, {1'b1, 8'h3C});
        repeat (3) step();

        // 5: CPU 01, DBG 02, CPU 03 back to back; check READ_LAT=2 instance
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h01;
        step(); cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'h02;
        step(); dbg_req = 1'b0; cpu_req = 1'b1; cpu_addr = 6'h03;
        step(); cpu_req = 1'b0;
        @(negedge clk); chk("t5 r1", {b_cpu_rvalid, b_dbg_rvalid, b_cpu_rdata}, {2'b10, 8'h11});
        step();
        @(negedge clk); chk("t5 r2", {b_cpu_rvalid, b_dbg_rvalid, b_dbg_rdata}, {2'b01, 8'h22});
        step();
        @(negedge clk); chk("t5 r3", {b_cpu_rvalid, b_dbg_rvalid, b_cpu_rdata}, {2'b10, 8'h33});
        repeat (3) step();

        // 6: reset right after a read is accepted
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h07;
        step(); cpu_req = 1'b0; reset = 1'b0;
        step(); reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6 flushed", {a_mem_read, a_cpu_rvalid, b_cpu_rvalid}, 3'b000);
            step();
        end

        repeat (4) step();
        chk("A queue drained", q_a.size(), 0);
        chk("B queue drained", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
